// File: rtl/step_clk_gen_if.sv
// Handshake bundle between the step/run clock generator and its environment.
// The slave side is the generator: it samples the raw controls and drives the CPU clock status.
interface step_clk_gen_if;
   logic        btn_step;
   logic        run_mode;
   logic        clk_on;
   logic        busy;
   logic [15:0] step_count;

   modport master (
      output btn_step,
      output run_mode,
      input  clk_on,
      input  busy,
      input  step_count
   );

   modport slave (
      input  btn_step,
      input  run_mode,
      output clk_on,
      output busy,
      output step_count
   );
endinterface

// File: rtl/step_clk_gen.sv
// CPU advance-clock generator: debounced single-step button or free-running RUN mode.
// clk_on is a registered pulse of HIGH_CYCLES followed by at least LOW_CYCLES low.
module step_clk_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20,
   parameter int unsigned HIGH_CYCLES     = 4,
   parameter int unsigned LOW_CYCLES      = 4
) (
   input  logic          clk,
   input  logic          rst,
   step_clk_gen_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HIGH = 2'd1;
   localparam logic [1:0] LOW  = 2'd2;

   localparam int unsigned TMR_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] HIGH_LAST = TMR_W'(HIGH_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOW_LAST  = TMR_W'(LOW_CYCLES - 1);

   logic             btn_m, btn_s;
   logic             run_m, run_s;
   logic             btn_db, btn_db_q;
   logic [CNT_W-1:0] db_cnt;
   logic             press;
   logic [1:0]       state;
   logic [TMR_W-1:0] tmr;
   logic             clk_on_q;
   logic [15:0]      step_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_m <= 1'b0;
         btn_s <= 1'b0;
         run_m <= 1'b0;
         run_s <= 1'b0;
      end else begin
         btn_m <= bus.btn_step;
         btn_s <= btn_m;
         run_m <= bus.run_mode;
         run_s <= run_m;
      end
   end

   // The accepted level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_db   <= 1'b0;
         btn_db_q <= 1'b0;
         db_cnt   <= '0;
      end else begin
         btn_db_q <= btn_db;
         if (btn_s == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_s;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign press = btn_db & ~btn_db_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tmr      <= '0;
         clk_on_q <= 1'b0;
         step_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (run_s | press) begin
                  state    <= HIGH;
                  clk_on_q <= 1'b1;
                  tmr      <= '0;
                  step_q   <= step_q + 16'd1;
               end
            end
            HIGH: begin
               if (tmr == HIGH_LAST) begin
                  state    <= LOW;
                  clk_on_q <= 1'b0;
                  tmr      <= '0;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            LOW: begin
               // Back-to-back re-entry into HIGH keeps the RUN period gap-free.
               if (tmr == LOW_LAST) begin
                  tmr <= '0;
                  if (run_s) begin
                     state    <= HIGH;
                     clk_on_q <= 1'b1;
                     step_q   <= step_q + 16'd1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               clk_on_q <= 1'b0;
               tmr      <= '0;
            end
         endcase
      end
   end

   assign bus.clk_on     = clk_on_q;
   assign bus.busy       = (state != IDLE);
   assign bus.step_count = step_q;

endmodule
